// File: rtl/ls_port_arbiter_pkg.sv
// Shared types and constants for the local-store port arbiter.
package ls_port_arbiter_pkg;

  localparam int LS_ADDR_W = 32;
  localparam int LS_QW_W   = 128;
  localparam int LS_LINE_W = 1024;

  // Low address bits cleared for quadword and line accesses.
  localparam int LS_QW_ALIGN_BITS   = 4;
  localparam int LS_LINE_ALIGN_BITS = 7;

  typedef enum logic [0:0] {
    ARB_IDLE    = 1'b0,
    ARB_IF_BUSY = 1'b1
  } ArbState;

  // One entry of the return pipeline: a read in flight and who issued it.
  typedef struct packed {
    logic vld;
    logic is_line;
  } RetTag;

  localparam RetTag RET_TAG_NONE = '{vld: 1'b0, is_line: 1'b0};

  // Wrap an address into the local store and clear its alignment bits.
  function automatic logic [0:LS_ADDR_W-1] ls_align(
    input logic [0:LS_ADDR_W-1] addr,
    input logic [0:LS_ADDR_W-1] mask,
    input int unsigned          align_bits
  );
    logic [0:LS_ADDR_W-1] low;
    low = (LS_ADDR_W'(1) << align_bits) - LS_ADDR_W'(1);
    return addr & mask & ~low;
  endfunction

endpackage

// File: rtl/ls_port_arbiter_if.sv
// Bundle of the requester, local-store and debug signals around the arbiter.
//
// Handshake: each requester raises *_req with its payload and holds both
// stable until it samples *_gnt high. gnt is combinational in the same cycle
// and the matching mem_* command is issued in that cycle; at most one gnt
// is high per cycle. Read returns are single-cycle *_rvalid pulses with no
// back-pressure.
interface ls_port_arbiter_if;
  import ls_port_arbiter_pkg::*;

  // load/store unit
  logic                 lsu_req;
  logic                 lsu_wr;
  logic [0:LS_ADDR_W-1] lsu_addr;
  logic [0:LS_QW_W-1]   lsu_wdata;
  logic                 lsu_gnt;
  logic                 lsu_rvalid;
  logic [0:LS_QW_W-1]   lsu_rdata;

  // instruction fetch
  logic                 if_req;
  logic [0:LS_ADDR_W-1] if_addr;
  logic                 if_gnt;
  logic                 if_rvalid;
  logic [0:LS_LINE_W-1] if_line;

  // local store
  logic [0:LS_ADDR_W-1] mem_addr;
  logic [0:LS_QW_W-1]   mem_wdata;
  logic                 mem_wr_en;
  logic                 mem_rd_en;
  logic                 mem_line_rd;
  logic [0:LS_QW_W-1]   mem_rdata;
  logic [0:LS_LINE_W-1] mem_line;

  // debug view of the arbiter state
  ArbState              dbg_state;
  logic [7:0]           dbg_busy_cnt;
  logic [7:0]           dbg_starve_cnt;

  // Arbiter side.
  modport slave (
    input  lsu_req, lsu_wr, lsu_addr, lsu_wdata,
    input  if_req, if_addr,
    input  mem_rdata, mem_line,
    output lsu_gnt, lsu_rvalid, lsu_rdata,
    output if_gnt, if_rvalid, if_line,
    output mem_addr, mem_wdata, mem_wr_en, mem_rd_en, mem_line_rd,
    output dbg_state, dbg_busy_cnt, dbg_starve_cnt
  );

  // Requesters and local-store side.
  modport master (
    output lsu_req, lsu_wr, lsu_addr, lsu_wdata,
    output if_req, if_addr,
    output mem_rdata, mem_line,
    input  lsu_gnt, lsu_rvalid, lsu_rdata,
    input  if_gnt, if_rvalid, if_line,
    input  mem_addr, mem_wdata, mem_wr_en, mem_rd_en, mem_line_rd,
    input  dbg_state, dbg_busy_cnt, dbg_starve_cnt
  );

endinterface

// File: rtl/ls_port_arbiter_ret.sv
// Fixed-latency return tag pipeline: a tag entering in cycle N appears on
// tag_o in cycle N+DEPTH. Reset empties every stage.
module ls_ret_pipe
  import ls_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 6
) (
  input  logic  clk,
  input  logic  rst,
  input  RetTag tag_i,
  output RetTag tag_o
);

  RetTag stage_q [DEPTH];
  RetTag stage_d [DEPTH];

  // Next stage contents: new tag at the head, everything else moves one on.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = RET_TAG_NONE;
    end
    stage_d[0] = tag_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RET_TAG_NONE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ls_port_arbiter.sv
// Local-store port arbiter: shares the single local-store port between the
// load/store unit (quadwords) and instruction fetch (lines), with starvation
// protection for fetch and in-order routing of read returns.
module ls_port_arbiter
  import ls_port_arbiter_pkg::*;
#(
  parameter int unsigned         RD_LAT     = 6,
  parameter int unsigned         LINE_CYC   = 2,
  parameter int unsigned         MAX_STARVE = 3,
  parameter logic [0:LS_ADDR_W-1] LS_MASK   = 32'h0000_7FFF
) (
  input logic              clk,
  input logic              rst,
  ls_port_arbiter_if.slave port_if
);

  localparam int BUSY_W   = (LINE_CYC > 1) ? $clog2(LINE_CYC) : 1;
  localparam int STARVE_W = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
  localparam logic [BUSY_W-1:0]   BUSY_LOAD  = BUSY_W'(LINE_CYC - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

  ArbState               state_q, state_d;
  logic [BUSY_W-1:0]     busy_cnt_q, busy_cnt_d;
  logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;

  logic                  lsu_gnt;
  logic                  if_gnt;
  logic [0:LS_ADDR_W-1]  mem_addr;
  logic [0:LS_QW_W-1]    mem_wdata;
  logic                  mem_wr_en;
  logic                  mem_rd_en;
  logic                  mem_line_rd;

  RetTag                 ret_tag_in;
  RetTag                 ret_tag_out;
  logic                  lsu_rvalid;
  logic                  if_rvalid;

  // Grant decision, local-store command and next FSM/counter state.
  always_comb begin
    state_d      = state_q;
    busy_cnt_d   = busy_cnt_q;
    starve_cnt_d = starve_cnt_q;
    lsu_gnt      = 1'b0;
    if_gnt       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wr_en    = 1'b0;
    mem_rd_en    = 1'b0;
    mem_line_rd  = 1'b0;
    ret_tag_in   = RET_TAG_NONE;

    if (!rst) begin
      unique case (state_q)
        ARB_IDLE: begin
          // Fetch wins when alone or when it has been passed over too often.
          if (port_if.if_req &&
              (!port_if.lsu_req || (starve_cnt_q == STARVE_MAX))) begin
            if_gnt       = 1'b1;
            mem_line_rd  = 1'b1;
            mem_addr     = ls_align(port_if.if_addr, LS_MASK, LS_LINE_ALIGN_BITS);
            ret_tag_in   = '{vld: 1'b1, is_line: 1'b1};
            starve_cnt_d = '0;
            if (LINE_CYC > 1) begin
              state_d    = ARB_IF_BUSY;
              busy_cnt_d = BUSY_LOAD;
            end
          end else if (port_if.lsu_req) begin
            lsu_gnt    = 1'b1;
            mem_addr   = ls_align(port_if.lsu_addr, LS_MASK, LS_QW_ALIGN_BITS);
            mem_wr_en  = port_if.lsu_wr;
            mem_rd_en  = !port_if.lsu_wr;
            mem_wdata  = port_if.lsu_wr ? port_if.lsu_wdata : '0;
            // Stores produce no return, so only loads enter the pipeline.
            ret_tag_in = '{vld: !port_if.lsu_wr, is_line: 1'b0};
            if (port_if.if_req && (starve_cnt_q != STARVE_MAX)) begin
              starve_cnt_d = starve_cnt_q + STARVE_W'(1);
            end
          end
        end
        ARB_IF_BUSY: begin
          // Line transfer still owns the port; count down its remaining cycles.
          if (busy_cnt_q <= BUSY_W'(1)) begin
            state_d    = ARB_IDLE;
            busy_cnt_d = '0;
          end else begin
            busy_cnt_d = busy_cnt_q - BUSY_W'(1);
          end
        end
        default: begin
          state_d    = ARB_IDLE;
          busy_cnt_d = '0;
        end
      endcase
    end
  end

  // FSM state and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      busy_cnt_q   <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      busy_cnt_q   <= busy_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  ls_ret_pipe #(
    .DEPTH (RD_LAT)
  ) u_ret_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (ret_tag_in),
    .tag_o (ret_tag_out)
  );

  // Returns are held off while reset is asserted so every output reads 0.
  assign lsu_rvalid = !rst && ret_tag_out.vld && !ret_tag_out.is_line;
  assign if_rvalid  = !rst && ret_tag_out.vld &&  ret_tag_out.is_line;

  assign port_if.lsu_gnt     = lsu_gnt;
  assign port_if.if_gnt      = if_gnt;
  assign port_if.mem_addr    = mem_addr;
  assign port_if.mem_wdata   = mem_wdata;
  assign port_if.mem_wr_en   = mem_wr_en;
  assign port_if.mem_rd_en   = mem_rd_en;
  assign port_if.mem_line_rd = mem_line_rd;

  assign port_if.lsu_rvalid  = lsu_rvalid;
  assign port_if.lsu_rdata   = lsu_rvalid ? port_if.mem_rdata : '0;
  assign port_if.if_rvalid   = if_rvalid;
  assign port_if.if_line     = if_rvalid ? port_if.mem_line : '0;

  assign port_if.dbg_state      = state_q;
  assign port_if.dbg_busy_cnt   = 8'(busy_cnt_q);
  assign port_if.dbg_starve_cnt = 8'(starve_cnt_q);

  a_one_gnt : assert property (@(posedge clk) disable iff (rst)
    !(lsu_gnt && if_gnt));

  a_one_ret : assert property (@(posedge clk) disable iff (rst)
    !(lsu_rvalid && if_rvalid));

  a_busy_quiet : assert property (@(posedge clk) disable iff (rst)
    (state_q == ARB_IF_BUSY) |-> !(mem_wr_en || mem_rd_en || mem_line_rd));

endmodule

// File: tb/tb_ls_port_arbiter.sv
// Directed bench for ls_port_arbiter. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, so "cycle N" is the clock period
// that ends with the N-th rising edge after the scenario starts.
module tb_ls_port_arbiter;
  import ls_port_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ls_port_arbiter_if bus_if ();

  ls_port_arbiter #(
    .RD_LAT     (6),
    .LINE_CYC   (2),
    .MAX_STARVE (3),
    .LS_MASK    (32'h0000_7FFF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .port_if (bus_if)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  function automatic logic [0:127] qw_pat(input int c);
    return {4{32'hD000_0000 | 32'(c)}};
  endfunction

  function automatic logic [0:1023] line_pat(input int c);
    return {32{32'hE000_0000 | 32'(c)}};
  endfunction

  task automatic drive_idle();
    bus_if.lsu_req   = 1'b0;
    bus_if.lsu_wr    = 1'b0;
    bus_if.lsu_addr  = '0;
    bus_if.lsu_wdata = '0;
    bus_if.if_req    = 1'b0;
    bus_if.if_addr   = '0;
  endtask

  task automatic drive_mem(input int c);
    bus_if.mem_rdata = qw_pat(c);
    bus_if.mem_line  = line_pat(c);
  endtask

  task automatic drive_lsu(input logic wr, input logic [0:31] addr, input logic [0:127] wdata);
    bus_if.lsu_req   = 1'b1;
    bus_if.lsu_wr    = wr;
    bus_if.lsu_addr  = addr;
    bus_if.lsu_wdata = wdata;
  endtask

  task automatic drive_if(input logic [0:31] addr);
    bus_if.if_req  = 1'b1;
    bus_if.if_addr = addr;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_lsu(1'b0, 32'h0000_0124, '0);
    drive_if(32'h0000_0400);
    drive_mem(1);
    #1;
    checks++;
    if ({bus_if.lsu_gnt, bus_if.if_gnt, bus_if.mem_wr_en, bus_if.mem_rd_en,
         bus_if.mem_line_rd, bus_if.lsu_rvalid, bus_if.if_rvalid} !== 7'b0) begin
      failures++;
      $display("FAIL reset_strobes: got %b exp 0000000", {bus_if.lsu_gnt, bus_if.if_gnt,
               bus_if.mem_wr_en, bus_if.mem_rd_en, bus_if.mem_line_rd,
               bus_if.lsu_rvalid, bus_if.if_rvalid});
    end
    checks++;
    if (bus_if.mem_addr !== 32'h0 || bus_if.mem_wdata !== '0 || bus_if.lsu_rdata !== '0) begin
      failures++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h exp all 0",
               bus_if.mem_addr, bus_if.mem_wdata, bus_if.lsu_rdata);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    #1;
    checks++;
    if (bus_if.dbg_state !== ARB_IDLE || bus_if.dbg_busy_cnt !== 8'd0 ||
        bus_if.dbg_starve_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: got state=%0d busy=%0d starve=%0d exp 0 0 0",
               bus_if.dbg_state, bus_if.dbg_busy_cnt, bus_if.dbg_starve_cnt);
    end
  endtask

  task automatic test_lsu_load();
    logic exp_v;
    @(negedge clk);
    drive_lsu(1'b0, 32'h0000_0124, '0);
    #1;
    checks++;
    if ({bus_if.lsu_gnt, bus_if.mem_rd_en, bus_if.mem_wr_en, bus_if.if_gnt} !== 4'b1100) begin
      failures++;
      $display("FAIL load_issue: got gnt/rd/wr/ifgnt=%b exp 1100",
               {bus_if.lsu_gnt, bus_if.mem_rd_en, bus_if.mem_wr_en, bus_if.if_gnt});
    end
    checks++;
    if (bus_if.mem_addr !== 32'h0000_0120) begin
      failures++;
      $display("FAIL load_addr: got %h exp 00000120", bus_if.mem_addr);
    end
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      drive_idle();
      drive_mem(c);
      #1;
      exp_v = (c == 6);
      checks++;
      if (bus_if.lsu_rvalid !== exp_v || bus_if.if_rvalid !== 1'b0) begin
        failures++;
        $display("FAIL load_ret c=%0d: got lsu/if rvalid=%b%b exp %b0",
                 c, bus_if.lsu_rvalid, bus_if.if_rvalid, exp_v);
      end
      checks++;
      if (bus_if.lsu_rdata !== (exp_v ? qw_pat(c) : 128'h0)) begin
        failures++;
        $display("FAIL load_rdata c=%0d: got %h exp %h", c, bus_if.lsu_rdata,
                 exp_v ? qw_pat(c) : 128'h0);
      end
    end
  endtask

  task automatic test_line_fetch();
    logic exp_l;
    logic exp_i;
    logic [0:1023] exp_line;
    @(negedge clk);
    drive_if(32'h0001_00C4);
    #1;
    checks++;
    if ({bus_if.if_gnt, bus_if.mem_line_rd, bus_if.lsu_gnt, bus_if.mem_rd_en} !== 4'b1100) begin
      failures++;
      $display("FAIL fetch_issue: got ifgnt/line/lsugnt/rd=%b exp 1100",
               {bus_if.if_gnt, bus_if.mem_line_rd, bus_if.lsu_gnt, bus_if.mem_rd_en});
    end
    checks++;
    if (bus_if.mem_addr !== 32'h0000_0080) begin
      failures++;
      $display("FAIL fetch_addr: got %h exp 00000080", bus_if.mem_addr);
    end
    // cycle 1: port still busy with the line
    @(negedge clk);
    drive_idle();
    drive_lsu(1'b0, 32'h0000_0200, '0);
    #1;
    checks++;
    if ({bus_if.lsu_gnt, bus_if.mem_rd_en, bus_if.mem_line_rd} !== 3'b000 ||
        bus_if.dbg_state !== ARB_IF_BUSY) begin
      failures++;
      $display("FAIL fetch_busy: got gnt/rd/line=%b state=%0d exp 000 state=1",
               {bus_if.lsu_gnt, bus_if.mem_rd_en, bus_if.mem_line_rd}, bus_if.dbg_state);
    end
    // cycle 2: held load goes through
    @(negedge clk);
    #1;
    checks++;
    if (bus_if.lsu_gnt !== 1'b1 || bus_if.mem_addr !== 32'h0000_0200) begin
      failures++;
      $display("FAIL fetch_after_busy: got gnt=%b addr=%h exp 1 00000200",
               bus_if.lsu_gnt, bus_if.mem_addr);
    end
    for (int c = 3; c <= 9; c++) begin
      @(negedge clk);
      drive_idle();
      drive_mem(c);
      #1;
      exp_i = (c == 6);
      exp_l = (c == 8);
      exp_line = exp_i ? line_pat(c) : '0;
      checks++;
      if (bus_if.if_rvalid !== exp_i || bus_if.lsu_rvalid !== exp_l) begin
        failures++;
        $display("FAIL fetch_ret c=%0d: got if/lsu rvalid=%b%b exp %b%b",
                 c, bus_if.if_rvalid, bus_if.lsu_rvalid, exp_i, exp_l);
      end
      checks++;
      if (bus_if.if_line !== exp_line) begin
        failures++;
        $display("FAIL fetch_line c=%0d: got low64 %h exp low64 %h",
                 c, bus_if.if_line[960:1023], exp_line[960:1023]);
      end
    end
  endtask

  task automatic test_starvation();
    logic exp_lg;
    logic exp_ig;
    logic exp_l;
    logic exp_i;
    logic [7:0] exp_starve;
    // lsu addr wraps and aligns to 0x300, fetch addr wraps to 0x400
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      drive_lsu(1'b0, 32'h0001_030F, '0);
      drive_if(32'h0000_8400);
      #1;
      exp_lg = (c == 0) || (c == 1) || (c == 2) || (c == 5);
      exp_ig = (c == 3);
      case (c)
        0: exp_starve = 8'd0;
        1: exp_starve = 8'd1;
        2: exp_starve = 8'd2;
        3: exp_starve = 8'd3;
        default: exp_starve = 8'd0;
      endcase
      checks++;
      if (bus_if.lsu_gnt !== exp_lg || bus_if.if_gnt !== exp_ig) begin
        failures++;
        $display("FAIL starve_gnt c=%0d: got lsu/if gnt=%b%b exp %b%b",
                 c, bus_if.lsu_gnt, bus_if.if_gnt, exp_lg, exp_ig);
      end
      checks++;
      if (bus_if.dbg_starve_cnt !== exp_starve) begin
        failures++;
        $display("FAIL starve_cnt c=%0d: got %0d exp %0d", c, bus_if.dbg_starve_cnt, exp_starve);
      end
      if (exp_lg || exp_ig) begin
        checks++;
        if (bus_if.mem_addr !== (exp_ig ? 32'h0000_0400 : 32'h0000_0300)) begin
          failures++;
          $display("FAIL starve_addr c=%0d: got %h exp %h", c, bus_if.mem_addr,
                   exp_ig ? 32'h0000_0400 : 32'h0000_0300);
        end
      end
    end
    // returns: loads from 0,1,2,5 and the line from 3, in issue order
    for (int c = 6; c <= 12; c++) begin
      @(negedge clk);
      drive_idle();
      drive_mem(c);
      #1;
      exp_l = (c == 6) || (c == 7) || (c == 8) || (c == 11);
      exp_i = (c == 9);
      checks++;
      if (bus_if.lsu_rvalid !== exp_l || bus_if.if_rvalid !== exp_i) begin
        failures++;
        $display("FAIL starve_ret c=%0d: got lsu/if rvalid=%b%b exp %b%b",
                 c, bus_if.lsu_rvalid, bus_if.if_rvalid, exp_l, exp_i);
      end
    end
  endtask

  task automatic test_store_load();
    logic exp_l;
    @(negedge clk);
    drive_lsu(1'b1, 32'h0000_0040, 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0BAD_BEEF);
    #1;
    checks++;
    if ({bus_if.lsu_gnt, bus_if.mem_wr_en, bus_if.mem_rd_en} !== 3'b110 ||
        bus_if.mem_addr !== 32'h0000_0040) begin
      failures++;
      $display("FAIL store_issue: got gnt/wr/rd=%b addr=%h exp 110 00000040",
               {bus_if.lsu_gnt, bus_if.mem_wr_en, bus_if.mem_rd_en}, bus_if.mem_addr);
    end
    checks++;
    if (bus_if.mem_wdata !== 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0BAD_BEEF) begin
      failures++;
      $display("FAIL store_wdata: got %h exp cafef00d123456789abcdef00badbeef", bus_if.mem_wdata);
    end
    @(negedge clk);
    drive_lsu(1'b0, 32'h0000_0040, '0);
    #1;
    checks++;
    if ({bus_if.lsu_gnt, bus_if.mem_wr_en, bus_if.mem_rd_en} !== 3'b101 ||
        bus_if.mem_addr !== 32'h0000_0040) begin
      failures++;
      $display("FAIL store_load_issue: got gnt/wr/rd=%b addr=%h exp 101 00000040",
               {bus_if.lsu_gnt, bus_if.mem_wr_en, bus_if.mem_rd_en}, bus_if.mem_addr);
    end
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      drive_idle();
      drive_mem(c);
      #1;
      exp_l = (c == 7);
      checks++;
      if (bus_if.lsu_rvalid !== exp_l || bus_if.if_rvalid !== 1'b0) begin
        failures++;
        $display("FAIL store_load_ret c=%0d: got lsu/if rvalid=%b%b exp %b0",
                 c, bus_if.lsu_rvalid, bus_if.if_rvalid, exp_l);
      end
    end
  endtask

  task automatic test_reset_mid_flight();
    logic exp_l;
    @(negedge clk);
    drive_lsu(1'b0, 32'h0000_0080, '0);
    #1;
    checks++;
    if (bus_if.lsu_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rmf_issue: got gnt=%b exp 1", bus_if.lsu_gnt);
    end
    @(negedge clk);
    drive_idle();
    // cycle 2: reset with both requests raised
    @(negedge clk);
    rst = 1'b1;
    drive_lsu(1'b1, 32'h0000_0100, 128'h1);
    drive_if(32'h0000_0200);
    #1;
    checks++;
    if ({bus_if.lsu_gnt, bus_if.if_gnt, bus_if.mem_wr_en, bus_if.mem_rd_en,
         bus_if.mem_line_rd, bus_if.lsu_rvalid, bus_if.if_rvalid} !== 7'b0 ||
        bus_if.mem_addr !== 32'h0 || bus_if.mem_wdata !== '0) begin
      failures++;
      $display("FAIL rmf_during_rst: got strobes=%b addr=%h exp 0000000 00000000",
               {bus_if.lsu_gnt, bus_if.if_gnt, bus_if.mem_wr_en, bus_if.mem_rd_en,
                bus_if.mem_line_rd, bus_if.lsu_rvalid, bus_if.if_rvalid}, bus_if.mem_addr);
    end
    for (int c = 3; c <= 9; c++) begin
      @(negedge clk);
      rst = 1'b0;
      drive_idle();
      drive_mem(c);
      #1;
      checks++;
      if (bus_if.lsu_rvalid !== 1'b0 || bus_if.if_rvalid !== 1'b0) begin
        failures++;
        $display("FAIL rmf_dropped c=%0d: got lsu/if rvalid=%b%b exp 00",
                 c, bus_if.lsu_rvalid, bus_if.if_rvalid);
      end
    end
    // line fetch at cycle 10, reset at 11, fresh load at 12
    @(negedge clk);
    drive_if(32'h0000_0300);
    #1;
    checks++;
    if (bus_if.if_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rmf_line_issue: got if_gnt=%b exp 1", bus_if.if_gnt);
    end
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    drive_lsu(1'b0, 32'h0000_0010, '0);
    #1;
    checks++;
    if (bus_if.lsu_gnt !== 1'b1 || bus_if.dbg_state !== ARB_IDLE) begin
      failures++;
      $display("FAIL rmf_regrant: got gnt=%b state=%0d exp 1 0", bus_if.lsu_gnt, bus_if.dbg_state);
    end
    for (int c = 13; c <= 19; c++) begin
      @(negedge clk);
      drive_idle();
      drive_mem(c);
      #1;
      exp_l = (c == 18);
      checks++;
      if (bus_if.lsu_rvalid !== exp_l || bus_if.if_rvalid !== 1'b0) begin
        failures++;
        $display("FAIL rmf_after c=%0d: got lsu/if rvalid=%b%b exp %b0",
                 c, bus_if.lsu_rvalid, bus_if.if_rvalid, exp_l);
      end
    end
  endtask

  task automatic test_interleaved();
    logic exp_l;
    logic exp_i;
    logic [0:1023] exp_line;
    @(negedge clk);
    drive_lsu(1'b0, 32'h0000_0010, '0);
    #1;
    checks++;
    if (bus_if.lsu_gnt !== 1'b1 || bus_if.mem_addr !== 32'h0000_0010) begin
      failures++;
      $display("FAIL inter_load: got gnt=%b addr=%h exp 1 00000010", bus_if.lsu_gnt, bus_if.mem_addr);
    end
    @(negedge clk);
    drive_idle();
    drive_if(32'h0000_1000);
    #1;
    checks++;
    if (bus_if.if_gnt !== 1'b1 || bus_if.mem_addr !== 32'h0000_1000) begin
      failures++;
      $display("FAIL inter_line: got gnt=%b addr=%h exp 1 00001000", bus_if.if_gnt, bus_if.mem_addr);
    end
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      drive_idle();
      drive_mem(c);
      #1;
      exp_l = (c == 6);
      exp_i = (c == 7);
      exp_line = exp_i ? line_pat(c) : '0;
      checks++;
      if (bus_if.lsu_rvalid !== exp_l || bus_if.if_rvalid !== exp_i) begin
        failures++;
        $display("FAIL inter_ret c=%0d: got lsu/if rvalid=%b%b exp %b%b",
                 c, bus_if.lsu_rvalid, bus_if.if_rvalid, exp_l, exp_i);
      end
      checks++;
      if (bus_if.lsu_rdata !== (exp_l ? qw_pat(c) : 128'h0) || bus_if.if_line !== exp_line) begin
        failures++;
        $display("FAIL inter_data c=%0d: got rdata=%h line_low64=%h exp %h %h",
                 c, bus_if.lsu_rdata, bus_if.if_line[960:1023],
                 exp_l ? qw_pat(c) : 128'h0, exp_line[960:1023]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive_idle();
    drive_mem(0);
    test_reset();
    test_lsu_load();
    test_line_fetch();
    test_starvation();
    test_store_load();
    test_reset_mid_flight();
    test_interleaved();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
